// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds all channel resets until PLL lock has been stable,
// releases them one by one, and re-asserts everything on lock loss or a debounced button.
module reset_sequencer #(
    parameter int NUM_CHANNELS    = 4,
    parameter int HOLD_CYCLES     = 63,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iLocked,
    input  logic                    iButton,
    output logic [NUM_CHANNELS-1:0] oReset,
    output logic                    oRunning,
    output logic [1:0]              oState,
    output logic [7:0]              oFaultCount
);

    localparam int STAGE_WIDTH = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CNT_WIDTH-1:0]   HOLD_LAST   = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   GAP_LAST    = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0]   DEB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_LAST  = STAGE_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_FIRST = STAGE_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [CNT_WIDTH-1:0]    cnt, cnt_next;
    logic [STAGE_WIDTH-1:0]  stage, stage_next;
    logic [NUM_CHANNELS-1:0] reset_next;
    logic                    running_next;
    logic [7:0]              fault_next;

    logic                 lock_meta, lock_s, btn_meta, btn_s, btn_db;
    logic [CNT_WIDTH-1:0] deb_cnt;
    logic                 abort;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two sync stages into one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
        end else begin
            lock_meta <= iLocked;
            lock_s    <= lock_meta;
            btn_meta  <= iButton;
            btn_s     <= btn_meta;
        end
    end

    // A button change is accepted only after it has been stable for DEBOUNCE_CYCLES.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            btn_db  <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s == btn_db) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_db  <= btn_s;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign abort  = !lock_s || btn_db;
    assign oState = state;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        stage_next   = stage;
        reset_next   = oReset;
        running_next = oRunning;
        fault_next   = oFaultCount;

        if (state == ST_ASSERT || abort) begin
            state_next   = abort ? ST_ASSERT : ST_HOLD;
            reset_next   = '1;
            running_next = 1'b0;
            cnt_next     = '0;
            stage_next   = '0;
            // Only lock loss out of RUN is a fault; button aborts are deliberate.
            if (state == ST_RUN && !lock_s && oFaultCount != 8'hFF)
                fault_next = oFaultCount + 8'd1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_next      = '0;
                        reset_next[0] = 1'b0;
                        if (NUM_CHANNELS == 1) begin
                            state_next   = ST_RUN;
                            running_next = 1'b1;
                            stage_next   = '0;
                        end else begin
                            state_next = ST_RELEASE;
                            stage_next = STAGE_FIRST;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt_next          = '0;
                        reset_next[stage] = 1'b0;
                        if (stage == STAGE_LAST) begin
                            state_next   = ST_RUN;
                            running_next = 1'b1;
                            stage_next   = '0;
                        end else begin
                            stage_next = stage + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    stage_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_ASSERT;
            cnt         <= '0;
            stage       <= '0;
            oReset      <= '1;
            oRunning    <= 1'b0;
            oFaultCount <= 8'd0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            stage       <= stage_next;
            oReset      <= reset_next;
            oRunning    <= running_next;
            oFaultCount <= fault_next;
        end
    end

endmodule
